// File: rtl/gomoku_board_engine.sv
// Gomoku board engine: holds the NxN board, commits moves through a
// request/ack handshake and checks for a win with a sequential scan of the
// four lines through the last stone. It also tracks the turn, the stone
// count and a draw on a full board.
module gomoku_board_engine #(
    parameter int BOARD_N = 16,
    parameter int WIN_LEN = 5,
    parameter int COORD_W = 4
) (
    input  logic                                    clock,
    input  logic                                    resetn,
    input  logic                                    put_req,
    input  logic [2*COORD_W-1:0]                    coordi,
    output logic                                    put_ack,
    output logic                                    put_reject,
    output logic                                    busy,
    output logic                                    turn,
    output logic [1:0]                              game_status,
    output logic [$clog2(BOARD_N*BOARD_N+1)-1:0]    move_count,
    output logic [2*BOARD_N*BOARD_N-1:0]            board
);
    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int CNT_W = $clog2(CELLS + 1);
    // Signed scan coordinates need two extra bits: one for the sign and one
    // for the overshoot past the far board edge.
    localparam int SW    = COORD_W + 2;
    localparam int RUN_W = $clog2(2 * WIN_LEN);
    localparam logic signed [SW-1:0] K_MAX = SW'(WIN_LEN - 1);
    localparam logic signed [SW-1:0] K_MIN = -K_MAX;
    localparam logic signed [SW-1:0] K_ONE = SW'(1);
    localparam logic signed [SW-1:0] N_S   = SW'(BOARD_N);
    localparam logic [COORD_W:0]     N_U   = (COORD_W + 1)'(BOARD_N);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH, OVER} state_t;

    state_t                 state_reg;
    logic [2*CELLS-1:0]     board_reg;
    logic [2*CELLS-1:0]     board_next;
    logic                   turn_reg;
    logic [1:0]             status_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   ack_reg;
    logic                   reject_reg;
    logic                   busy_reg;
    logic [COORD_W-1:0]     last_row_reg;
    logic [COORD_W-1:0]     last_col_reg;
    logic [1:0]             last_color_reg;
    logic [1:0]             dir_reg;
    logic signed [SW-1:0]   k_reg;
    logic [RUN_W-1:0]       run_reg;
    logic                   win_reg;

    logic [COORD_W-1:0]     req_row;
    logic [COORD_W-1:0]     req_col;
    logic                   req_in_range;
    logic                   req_occupied;
    logic                   accept_ok;
    logic [1:0]             turn_color;
    logic signed [SW-1:0]   row_off;
    logic signed [SW-1:0]   col_off;
    logic signed [SW-1:0]   scan_row;
    logic signed [SW-1:0]   scan_col;
    logic                   on_board;
    logic [1:0]             scan_cell;
    logic                   cell_match;
    logic [RUN_W-1:0]       run_inc;
    logic                   hits_win;

    logic [CELLS-1:0]       req_hit;
    logic [CELLS-1:0]       cell_occ;
    logic [CELLS-1:0]       scan_p0;
    logic [CELLS-1:0]       scan_p1;

    assign req_row      = coordi[2*COORD_W-1:COORD_W];
    assign req_col      = coordi[COORD_W-1:0];
    assign req_in_range = ({1'b0, req_row} < N_U) && ({1'b0, req_col} < N_U);
    assign turn_color   = {turn_reg, ~turn_reg};

    // Per-cell decode: request-address hit, occupancy, and scan-address read.
    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int ROW = gi / BOARD_N;
            localparam int COL = gi % BOARD_N;
            logic scan_hit;
            assign req_hit[gi]  = (req_row == COORD_W'(ROW)) && (req_col == COORD_W'(COL));
            assign scan_hit     = (scan_row == SW'(ROW)) && (scan_col == SW'(COL));
            assign cell_occ[gi] = |board_reg[2*gi +: 2];
            assign scan_p0[gi]  = scan_hit & board_reg[2*gi];
            assign scan_p1[gi]  = scan_hit & board_reg[2*gi+1];
        end
    endgenerate

    assign req_occupied = |(req_hit & cell_occ);
    assign accept_ok    = req_in_range && !req_occupied && (status_reg == 2'b00);

    // Step vector for the current direction scaled by the offset k.
    always_comb begin
        row_off = '0;
        col_off = k_reg;
        case (dir_reg)
            2'd0:    begin row_off = '0;     col_off = k_reg; end
            2'd1:    begin row_off = k_reg;  col_off = '0;    end
            2'd2:    begin row_off = k_reg;  col_off = k_reg; end
            default: begin row_off = -k_reg; col_off = k_reg; end
        endcase
    end

    assign scan_row   = $signed({2'b00, last_row_reg}) + row_off;
    assign scan_col   = $signed({2'b00, last_col_reg}) + col_off;
    // Signed bounds keep off-board cells from aliasing onto real ones.
    assign on_board   = !scan_row[SW-1] && !scan_col[SW-1] && (scan_row < N_S) && (scan_col < N_S);
    assign scan_cell  = {|scan_p1, |scan_p0};
    assign cell_match = on_board && (scan_cell == last_color_reg);
    assign run_inc    = run_reg + 1'b1;
    assign hits_win   = cell_match && (run_inc == RUN_W'(WIN_LEN));

    // Board image with the requested cell painted in the mover's colour.
    always_comb begin
        board_next = board_reg;
        for (int i = 0; i < CELLS; i++) begin
            if (req_hit[i]) begin
                board_next[2*i +: 2] = turn_color;
            end
        end
    end

    // Game FSM: accept/reject moves, scan around the last stone, resolve outcome.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            board_reg      <= '0;
            turn_reg       <= 1'b0;
            status_reg     <= 2'b00;
            count_reg      <= '0;
            ack_reg        <= 1'b0;
            reject_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            last_row_reg   <= '0;
            last_col_reg   <= '0;
            last_color_reg <= 2'b00;
            dir_reg        <= 2'd0;
            k_reg          <= K_MIN;
            run_reg        <= '0;
            win_reg        <= 1'b0;
        end else begin
            ack_reg    <= 1'b0;
            reject_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (put_req) begin
                        if (accept_ok) begin
                            board_reg      <= board_next;
                            count_reg      <= count_reg + 1'b1;
                            last_row_reg   <= req_row;
                            last_col_reg   <= req_col;
                            last_color_reg <= turn_color;
                            dir_reg        <= 2'd0;
                            k_reg          <= K_MIN;
                            run_reg        <= '0;
                            win_reg        <= 1'b0;
                            ack_reg        <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= SCAN;
                        end else begin
                            reject_reg <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    run_reg <= cell_match ? run_inc : '0;
                    if (hits_win) begin
                        win_reg <= 1'b1;
                    end
                    if (k_reg == K_MAX) begin
                        k_reg   <= K_MIN;
                        run_reg <= '0;
                        if (dir_reg == 2'd3) begin
                            state_reg <= FINISH;
                        end else begin
                            dir_reg <= dir_reg + 1'b1;
                        end
                    end else begin
                        k_reg <= k_reg + K_ONE;
                    end
                end
                FINISH: begin
                    busy_reg <= 1'b0;
                    if (win_reg) begin
                        status_reg <= last_color_reg;
                        state_reg  <= OVER;
                    end else if (count_reg == CNT_W'(CELLS)) begin
                        status_reg <= 2'b11;
                        state_reg  <= OVER;
                    end else begin
                        turn_reg  <= ~turn_reg;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    if (put_req) begin
                        reject_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign put_ack     = ack_reg;
    assign put_reject  = reject_reg;
    assign busy        = busy_reg;
    assign turn        = turn_reg;
    assign game_status = status_reg;
    assign move_count  = count_reg;
    assign board       = board_reg;

endmodule

// File: tb/tb_gomoku_board_engine.sv
// Directed testbench for gomoku_board_engine: a default 16x16 instance, a
// 16x16 instance with 5-bit coordinates for out-of-range rows, and a 3x3
// instance with WIN_LEN=3 for draw and mid-scan reset.
module tb_gomoku_board_engine;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetn;
    int checks_cnt = 0;
    int errors_cnt = 0;

    // Instance A: defaults 16 / 5 / 4
    logic         a_req;
    logic [7:0]   a_coord;
    logic         a_ack, a_rej, a_busy, a_turn;
    logic [1:0]   a_status;
    logic [8:0]   a_count;
    logic [511:0] a_board;

    // Instance B: 16 / 5 / 5
    logic         b_req;
    logic [9:0]   b_coord;
    logic         b_ack, b_rej, b_busy, b_turn;
    logic [1:0]   b_status;
    logic [8:0]   b_count;
    logic [511:0] b_board;

    // Instance C: 3 / 3 / 2
    logic         c_req;
    logic [3:0]   c_coord;
    logic         c_ack, c_rej, c_busy, c_turn;
    logic [1:0]   c_status;
    logic [3:0]   c_count;
    logic [17:0]  c_board;

    gomoku_board_engine #(.BOARD_N(16), .WIN_LEN(5), .COORD_W(4)) u_dut_a (
        .clock(clock), .resetn(resetn), .put_req(a_req), .coordi(a_coord),
        .put_ack(a_ack), .put_reject(a_rej), .busy(a_busy), .turn(a_turn),
        .game_status(a_status), .move_count(a_count), .board(a_board)
    );

    gomoku_board_engine #(.BOARD_N(16), .WIN_LEN(5), .COORD_W(5)) u_dut_b (
        .clock(clock), .resetn(resetn), .put_req(b_req), .coordi(b_coord),
        .put_ack(b_ack), .put_reject(b_rej), .busy(b_busy), .turn(b_turn),
        .game_status(b_status), .move_count(b_count), .board(b_board)
    );

    gomoku_board_engine #(.BOARD_N(3), .WIN_LEN(3), .COORD_W(2)) u_dut_c (
        .clock(clock), .resetn(resetn), .put_req(c_req), .coordi(c_coord),
        .put_ack(c_ack), .put_reject(c_rej), .busy(c_busy), .turn(c_turn),
        .game_status(c_status), .move_count(c_count), .board(c_board)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [1:0] cell_a(input int r, input int c);
        return a_board[2*(r*16+c) +: 2];
    endfunction

    function automatic logic [1:0] cell_c(input int r, input int c);
        return c_board[2*(r*3+c) +: 2];
    endfunction

    // One request on A; returns the pulses seen in the next cycle and the
    // number of cycles busy stayed high (bounded).
    task automatic put_a(input int r, input int c, output logic ack, output logic rej, output int bc);
        a_coord = {4'(r), 4'(c)};
        a_req   = 1'b1;
        tick();
        a_req = 1'b0;
        ack   = a_ack;
        rej   = a_rej;
        bc    = 0;
        while (a_busy && bc < 200) begin
            bc++;
            tick();
        end
    endtask

    task automatic put_c(input int r, input int c, output logic ack, output logic rej, output int bc);
        c_coord = {2'(r), 2'(c)};
        c_req   = 1'b1;
        tick();
        c_req = 1'b0;
        ack   = c_ack;
        rej   = c_rej;
        bc    = 0;
        while (c_busy && bc < 200) begin
            bc++;
            tick();
        end
    endtask

    task automatic play_a(input int r, input int c);
        logic ack, rej;
        int bc;
        put_a(r, c, ack, rej, bc);
        check_val($sformatf("a_ack(%0d,%0d)", r, c), 64'(ack), 64'd1);
        check_val($sformatf("a_busy_len(%0d,%0d)", r, c), 64'(bc), 64'd37);
    endtask

    task automatic play_c(input int r, input int c);
        logic ack, rej;
        int bc;
        put_c(r, c, ack, rej, bc);
        check_val($sformatf("c_ack(%0d,%0d)", r, c), 64'(ack), 64'd1);
        check_val($sformatf("c_busy_len(%0d,%0d)", r, c), 64'(bc), 64'd21);
    endtask

    int g1 [9][2]  = '{'{7,3}, '{10,0}, '{7,4}, '{10,2}, '{7,5}, '{10,4}, '{7,6}, '{10,6}, '{7,7}};
    int g2 [10][2] = '{'{15,0}, '{4,0}, '{15,2}, '{3,1}, '{15,4}, '{2,2}, '{15,6}, '{1,3}, '{15,8}, '{0,4}};
    int g3 [9][2]  = '{'{5,12}, '{9,1}, '{5,13}, '{9,3}, '{5,14}, '{9,5}, '{5,15}, '{9,7}, '{6,0}};
    int gc [9][2]  = '{'{0,0}, '{0,1}, '{0,2}, '{1,1}, '{1,0}, '{1,2}, '{2,1}, '{2,0}, '{2,2}};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, rej;
        int   bc;
        resetn  = 1'b1;
        a_req   = 1'b0; a_coord = '0;
        b_req   = 1'b0; b_coord = '0;
        c_req   = 1'b0; c_coord = '0;
        do_reset();

        // Reset state
        check_val("rst_status", 64'(a_status), 64'd0);
        check_val("rst_count",  64'(a_count),  64'd0);
        check_val("rst_turn",   64'(a_turn),   64'd0);
        check_val("rst_busy",   64'(a_busy),   64'd0);
        check_val("rst_board",  64'(|a_board), 64'd0);

        // First move and its latency
        put_a(3, 4, ack, rej, bc);
        check_val("t1_ack",      64'(ack), 64'd1);
        check_val("t1_rej",      64'(rej), 64'd0);
        check_val("t1_busy_len", 64'(bc),  64'd37);
        check_val("t1_cell",     64'(cell_a(3, 4)), 64'd1);
        check_val("t1_turn",     64'(a_turn),  64'd1);
        check_val("t1_count",    64'(a_count), 64'd1);

        // Occupied cell
        put_a(3, 4, ack, rej, bc);
        check_val("t2_rej",      64'(rej), 64'd1);
        check_val("t2_ack",      64'(ack), 64'd0);
        check_val("t2_busy_len", 64'(bc),  64'd0);
        check_val("t2_turn",     64'(a_turn),  64'd1);
        check_val("t2_count",    64'(a_count), 64'd1);

        // Request held while busy is ignored
        a_coord = {4'd0, 4'd0};
        a_req   = 1'b1;
        tick();
        check_val("t3_ack", 64'(a_ack), 64'd1);
        a_coord = {4'd0, 4'd1};
        tick();
        check_val("t3_busy_ack", 64'(a_ack), 64'd0);
        check_val("t3_busy_rej", 64'(a_rej), 64'd0);
        a_req = 1'b0;
        bc = 0;
        while (a_busy && bc < 200) begin
            bc++;
            tick();
        end
        check_val("t3_busy_done", 64'(a_busy), 64'd0);
        check_val("t3_cell00",    64'(cell_a(0, 0)), 64'd2);
        check_val("t3_cell01",    64'(cell_a(0, 1)), 64'd0);
        check_val("t3_count",     64'(a_count), 64'd2);
        check_val("t3_turn",      64'(a_turn),  64'd0);

        // Horizontal p0 five on row 7
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check_val("t4_status_before", 64'(a_status), 64'd0);
            play_a(g1[i][0], g1[i][1]);
        end
        check_val("t4_status", 64'(a_status), 64'd1);
        check_val("t4_turn",   64'(a_turn),   64'd0);
        check_val("t4_count",  64'(a_count),  64'd11);
        put_a(12, 12, ack, rej, bc);
        check_val("t4_over_rej",   64'(rej), 64'd1);
        check_val("t4_over_ack",   64'(ack), 64'd0);
        check_val("t4_over_count", 64'(a_count), 64'd11);
        check_val("t4_over_cell",  64'(cell_a(12, 12)), 64'd0);

        // Row 16 is off a 16x16 board when coordinates are 5 bits wide
        b_coord = {5'd16, 5'd0};
        b_req   = 1'b1;
        tick();
        b_req = 1'b0;
        check_val("t3b_rej", 64'(b_rej), 64'd1);
        check_val("t3b_ack", 64'(b_ack), 64'd0);
        b_coord = {5'd15, 5'd15};
        b_req   = 1'b1;
        tick();
        b_req = 1'b0;
        check_val("t3b_ack_corner", 64'(b_ack), 64'd1);
        bc = 0;
        while (b_busy && bc < 200) begin
            bc++;
            tick();
        end
        check_val("t3b_count", 64'(b_count), 64'd1);
        check_val("t3b_cell",  64'(b_board[2*255 +: 2]), 64'd1);
        check_val("t3b_row16_clear", 64'(|b_board[511:0] == 1'b1 && b_board[509:0] == '0), 64'd1);

        // Anti-diagonal p1 five touching the top edge
        do_reset();
        for (int i = 0; i < 10; i++) play_a(g2[i][0], g2[i][1]);
        check_val("t5_status", 64'(a_status), 64'd2);
        check_val("t5_turn",   64'(a_turn),   64'd1);
        check_val("t5_count",  64'(a_count),  64'd10);

        // Four at the right edge plus one at the start of the next row
        do_reset();
        for (int i = 0; i < 9; i++) play_a(g3[i][0], g3[i][1]);
        check_val("t5_wrap_status", 64'(a_status), 64'd0);
        check_val("t5_wrap_turn",   64'(a_turn),   64'd1);
        check_val("t5_wrap_count",  64'(a_count),  64'd9);

        // 3x3 draw
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check_val("t6_status_before", 64'(c_status), 64'd0);
            play_c(gc[i][0], gc[i][1]);
        end
        check_val("t6_status", 64'(c_status), 64'd3);
        check_val("t6_count",  64'(c_count),  64'd9);
        check_val("t6_cell22", 64'(cell_c(2, 2)), 64'd1);
        check_val("t6_cell20", 64'(cell_c(2, 0)), 64'd2);

        // Reset in the middle of a scan
        do_reset();
        c_coord = {2'd1, 2'd1};
        c_req   = 1'b1;
        tick();
        c_req = 1'b0;
        check_val("t6_mid_ack", 64'(c_ack), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check_val("t6_mid_busy", 64'(c_busy), 64'd1);
        resetn = 1'b0;
        tick();
        check_val("t6_rst_busy",   64'(c_busy),   64'd0);
        check_val("t6_rst_ack",    64'(c_ack),    64'd0);
        check_val("t6_rst_count",  64'(c_count),  64'd0);
        check_val("t6_rst_turn",   64'(c_turn),   64'd0);
        check_val("t6_rst_status", 64'(c_status), 64'd0);
        check_val("t6_rst_board",  64'(|c_board), 64'd0);
        resetn = 1'b1;
        play_c(1, 1);
        check_val("t6_after_turn", 64'(c_turn), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
